// File: rtl/gf2m_mul_arb.sv
// gf2m_mul_arb: two-port round-robin front end for a single multi-cycle
// GF(2^m) multiplier. One operation in flight; completion or timeout is
// reported back to the port that owns the operation.
module gf2m_mul_arb #(
  parameter int WIDTH   = 101,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] op_a0,
  input  logic [WIDTH-1:0] op_b0,
  input  logic [WIDTH-1:0] op_a1,
  input  logic [WIDTH-1:0] op_b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_op_a,
  output logic [WIDTH-1:0] mul_op_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_op_c,
  output logic             mul_rst_b
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             prio;       // 1: port 1 wins a tie
  logic             owner;      // port of the operation in flight
  logic             sel;        // port that would be granted this cycle
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] res_q;
  logic             done_q;
  logic             err_q;
  logic             wait_last;

  // The multiplier is held in reset for exactly as long as this block is.
  assign mul_rst_b = ~rst;
  assign mul_op_a  = op_a_q;
  assign mul_op_b  = op_b_q;
  assign res       = res_q;
  assign wait_last = (wait_cnt == CNT_LAST);

  // State, arbitration pointer, operand capture, wait timer and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wait_cnt <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (req0 || req1) begin
            owner  <= sel;
            prio   <= ~sel;
            op_a_q <= sel ? op_a1 : op_a0;
            op_b_q <= sel ? op_b1 : op_b0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          // A completion on the last timer cycle still counts as a completion.
          if (mul_done) begin
            res_q  <= mul_op_c;
            done_q <= 1'b1;
          end else if (wait_last) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  // Next-state logic, grant selection and per-port output steering.
  always_comb begin
    state_next = state;
    sel        = req1 & (~req0 | prio);
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mul_start  = 1'b0;
    busy       = (state != IDLE);
    done0      = done_q & ~owner;
    done1      = done_q & owner;
    err0       = err_q & ~owner;
    err1       = err_q & owner;
    case (state)
      IDLE: begin
        if (req0 || req1) state_next = ISSUE;
      end
      ISSUE: begin
        gnt0       = ~owner;
        gnt1       = owner;
        mul_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mul_done || wait_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gf2m_mul_arb.sv
// Scoreboard bench for gf2m_mul_arb with a behavioural multiplier stub.
module tb_gf2m_mul_arb;
  localparam int WIDTH   = 101;
  localparam int TIMEOUT = 32;
  localparam logic [WIDTH-1:0] POLY = {{(WIDTH-8){1'b0}}, 8'hC3};

  typedef logic [WIDTH-1:0] elem_t;
  typedef struct {
    int    kind;   // 0 grant, 1 done, 2 error
    int    port;
    elem_t res;
  } ev_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  req0 = 1'b0, req1 = 1'b0;
  elem_t op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
  logic  gnt0, gnt1, done0, done1, err0, err1, busy, mul_start, mul_done, mul_rst_b;
  elem_t res, mul_op_a, mul_op_b, mul_op_c;
  logic  stub_done = 1'b0, stray_done = 1'b0;
  elem_t stub_c = '0, stray_c = '0;

  assign mul_done = stub_done | stray_done;
  assign mul_op_c = stray_done ? stray_c : stub_c;

  gf2m_mul_arb #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .res(res), .busy(busy),
    .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_done(mul_done), .mul_op_c(mul_op_c), .mul_rst_b(mul_rst_b)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  ev_t   exp_q[$];
  int    lat_q[$];
  elem_t model_res = '0;
  int    ptr = 0;

  // Polynomial-basis product modulo x^101 + x^7 + x^6 + x + 1.
  function automatic elem_t gf_mul(input elem_t a, input elem_t b);
    elem_t r = '0;
    elem_t x = a;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) r ^= x;
      x = {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
    end
    return r;
  endfunction

  function automatic elem_t rand_elem();
    elem_t r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic check(input string name, input elem_t act, input elem_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected events for one operation; lat 1..TIMEOUT completes, 0 never completes.
  task automatic push_op(input int p, input elem_t a, input elem_t b, input int lat);
    ev_t e;
    e = '{kind: 0, port: p, res: '0};
    exp_q.push_back(e);
    lat_q.push_back(lat);
    if (lat >= 1 && lat <= TIMEOUT) begin
      model_res = gf_mul(a, b);
      e = '{kind: 1, port: p, res: model_res};
    end else begin
      e = '{kind: 2, port: p, res: model_res};
    end
    exp_q.push_back(e);
  endtask

  // Multiplier stub: answers lat cycles after a start; stops on reset.
  task automatic stub_loop();
    int    cnt = 0;
    elem_t prod = '0;
    forever begin
      @(negedge clk);
      stub_done = 1'b0;
      if (rst) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          stub_done = 1'b1;
          stub_c    = prod;
        end
      end
      if (!rst && mul_start) begin
        int l;
        l    = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        prod = gf_mul(mul_op_a, mul_op_b);
        cnt  = l;
      end
    end
  endtask

  // Monitor: every grant/done/error is popped against the expected queue.
  task automatic monitor_loop();
    logic [5:0] v;
    ev_t        e;
    forever begin
      @(negedge clk);
      v = {err1, err0, done1, done0, gnt1, gnt0};
      if (v != 6'd0) begin
        checks++;
        if ($countones(v) != 1) begin
          errors++;
          $display("FAIL onehot_events: got %b expected a single bit", v);
        end
        for (int i = 0; i < 6; i++) begin
          if (v[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_event: got kind=%0d port=%0d expected none", i / 2, i % 2);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != i / 2 || e.port != i % 2 || (e.kind != 0 && res !== e.res)) begin
                errors++;
                $display("FAIL event: got kind=%0d port=%0d res=%h expected kind=%0d port=%0d res=%h",
                         i / 2, i % 2, res, e.kind, e.port, e.res);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic drive_port(input int p, input elem_t a, input elem_t b);
    bit got = 1'b0;
    if (p == 0) begin req0 = 1'b1; op_a0 = a; op_b0 = b; end
    else        begin req1 = 1'b1; op_a1 = a; op_b1 = b; end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) got = 1'b1;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait port=%0d: got no grant expected grant within 400 cycles", p);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_mul_rst_b"}, elem_t'(mul_rst_b), '0);
    check({tag, "_res"}, res, '0);
    check({tag, "_busy"}, elem_t'(busy), '0);
    check({tag, "_outs"}, elem_t'({gnt0, gnt1, done0, done1, err0, err1, mul_start}), '0);
    check({tag, "_ops"}, mul_op_a | mul_op_b, '0);
    rst = 1'b0;
    #1 check({tag, "_mul_rst_b_rel"}, elem_t'(mul_rst_b), elem_t'(1'b1));
    model_res = '0;
    ptr = 0;
    lat_q.delete();
    @(negedge clk);
  endtask

  initial begin
    elem_t one, bval, a, b, a1, b1;
    int    n;
    bit    seen;
    one = elem_t'(1);

    fork
      stub_loop();
      monitor_loop();
    join_none

    do_reset("rst0");

    // Single request with x^0 operand: product equals the other operand.
    bval = rand_elem();
    push_op(0, one, bval, 3);
    req0 = 1'b1; op_a0 = one; op_b0 = bval;
    @(negedge clk);
    check("single_gnt0", elem_t'(gnt0), elem_t'(1'b1));
    check("single_mul_start", elem_t'(mul_start), elem_t'(1'b1));
    check("single_mul_op_a", mul_op_a, one);
    check("single_mul_op_b", mul_op_b, bval);
    req0 = 1'b0;
    @(negedge clk);
    check("single_pulse_width", elem_t'({gnt0, mul_start}), '0);
    check("single_busy", elem_t'(busy), elem_t'(1'b1));
    n = 1; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = done0;
    end
    check("single_done_latency", elem_t'(n), elem_t'(4));
    check("single_res", res, bval);
    check("single_idle", elem_t'(busy), '0);
    drain(10);

    // Timeout with a silent multiplier; res keeps the previous product.
    a = rand_elem(); b = rand_elem();
    push_op(0, a, b, 0);
    req0 = 1'b1; op_a0 = a; op_b0 = b;
    @(negedge clk);
    req0 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = err0;
    end
    check("timeout_latency", elem_t'(n), elem_t'(TIMEOUT + 1));
    check("timeout_res", res, bval);
    check("timeout_busy", elem_t'(busy), '0);
    drain(10);

    // Reset in WAIT abandons the operation; a stray mul_done in IDLE is ignored.
    exp_q.push_back('{kind: 0, port: 0, res: '0});
    lat_q.push_back(0);
    req0 = 1'b1; op_a0 = rand_elem(); op_b0 = rand_elem();
    @(negedge clk);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_mul_rst_b", elem_t'(mul_rst_b), '0);
    @(negedge clk);
    check("midrst_res", res, '0);
    check("midrst_busy", elem_t'(busy), '0);
    rst = 1'b0;
    model_res = '0; ptr = 0; lat_q.delete();
    @(negedge clk);
    stray_done = 1'b1; stray_c = rand_elem();
    @(negedge clk);
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_done_res", res, '0);
    drain(5);

    // Withdrawn request during WAIT, and a completion on the final timer cycle.
    a = rand_elem(); b = rand_elem();
    push_op(0, a, b, TIMEOUT);
    req0 = 1'b1; op_a0 = a; op_b0 = b;
    @(negedge clk);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    req1 = 1'b1; op_a1 = rand_elem(); op_b1 = rand_elem();
    @(negedge clk);
    req1 = 1'b0;
    drain(100);
    check("coincide_res", res, gf_mul(a, b));
    repeat (3) @(negedge clk);

    // Contention from reset, then an immediate second round.
    do_reset("rst1");
    for (int round = 0; round < 2; round++) begin
      a = rand_elem(); b = rand_elem(); a1 = rand_elem(); b1 = rand_elem();
      push_op(0, a, b, 2);
      push_op(1, a1, b1, 4);
      fork
        drive_port(0, a, b);
        drive_port(1, a1, b1);
      join
      drain(100);
    end

    // Randomized traffic against a round-robin model.
    do_reset("rst2");
    for (int it = 0; it < 30; it++) begin
      int pat, first, l0, l1, r;
      pat = $urandom_range(0, 2);
      a = rand_elem(); b = rand_elem(); a1 = rand_elem(); b1 = rand_elem();
      r = $urandom_range(0, 7);
      l0 = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
      r = $urandom_range(0, 7);
      l1 = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
      if (pat == 2) begin
        first = ptr;
        if (first == 0) begin push_op(0, a, b, l0); push_op(1, a1, b1, l1); end
        else            begin push_op(1, a1, b1, l1); push_op(0, a, b, l0); end
        ptr = first;
      end else if (pat == 0) begin
        push_op(0, a, b, l0);
        ptr = 1;
      end else begin
        push_op(1, a1, b1, l1);
        ptr = 0;
      end
      fork
        begin if (pat != 1) drive_port(0, a, b); end
        begin if (pat != 0) drive_port(1, a1, b1); end
      join
      drain(200);
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", elem_t'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
